// File: rtl/noc_packet_sink_if.sv
// Flit ejection and payload delivery bundle for the packet sink.
// Pure wiring, no latency of its own.
// Flits back-pressure with flit_ready; payload beats back-pressure with pkt_ready.
interface noc_packet_sink_if #(
  parameter int NOC_DW = 64,
  parameter int ID_X_W = 2,
  parameter int ID_Y_W = 2
);
  logic              flit_valid;
  logic [NOC_DW+1:0] flit_in;
  logic              flit_ready;
  logic              pkt_valid;
  logic              pkt_ready;
  logic [NOC_DW-1:0] pkt_data;
  logic              pkt_last;
  logic              pkt_err;
  logic [ID_X_W-1:0] pkt_src_x;
  logic [ID_Y_W-1:0] pkt_src_y;
  logic              err_valid;
  logic [2:0]        err_code;
  logic [15:0]       pkt_count;
  logic [7:0]        err_count;

  // Router / consumer side: drives flits and consumes payload beats.
  modport master (
    output flit_valid, flit_in, pkt_ready,
    input  flit_ready, pkt_valid, pkt_data, pkt_last, pkt_err,
    input  pkt_src_x, pkt_src_y, err_valid, err_code, pkt_count, err_count
  );

  // Sink side: accepts flits and produces payload beats and status.
  modport slave (
    input  flit_valid, flit_in, pkt_ready,
    output flit_ready, pkt_valid, pkt_data, pkt_last, pkt_err,
    output pkt_src_x, pkt_src_y, err_valid, err_code, pkt_count, err_count
  );
endinterface

// File: rtl/noc_packet_sink.sv
// Ejection network interface: checks framing/routing of flits, delivers payload beats.
// Latency: a data flit accepted at edge k is visible on pkt_valid after edge k.
// Backpressure: flit_ready drops while the payload FIFO is full, stalling every flit type.
module noc_packet_sink #(
  parameter int NOC_DW     = 64,
  parameter int ID_X_W     = 2,
  parameter int ID_Y_W     = 2,
  parameter int LEN_W      = 8,
  parameter int X_ID       = 0,
  parameter int Y_ID       = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int MARK_W     = 4
) (
  input  logic               noc_clk,
  input  logic               noc_rst,
  noc_packet_sink_if.slave   bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  // Header/tail field positions, MSB first after the leading marker.
  localparam int HM_LSB  = NOC_DW - MARK_W;
  localparam int SX_LSB  = HM_LSB - ID_X_W;
  localparam int SY_LSB  = SX_LSB - ID_Y_W;
  localparam int DX_LSB  = SY_LSB - ID_X_W;
  localparam int DY_LSB  = DX_LSB - ID_Y_W;
  localparam int LEN_LSB = DY_LSB - LEN_W;

  localparam logic [MARK_W-1:0] HEAD_H = MARK_W'(4'hA);
  localparam logic [MARK_W-1:0] HEAD_E = MARK_W'(4'h5);
  localparam logic [MARK_W-1:0] TAIL_H = MARK_W'(4'hC);
  localparam logic [MARK_W-1:0] TAIL_E = MARK_W'(4'h3);

  localparam logic [2:0] E_NONE     = 3'd0;
  localparam logic [2:0] E_STRAY    = 3'd1;
  localparam logic [2:0] E_BAD_HEAD = 3'd2;
  localparam logic [2:0] E_MISROUTE = 3'd3;
  localparam logic [2:0] E_SHORT    = 3'd4;
  localparam logic [2:0] E_BAD_TAIL = 3'd5;

  typedef enum logic [1:0] {IDLE, PAYLOAD, TAIL, DROP} state_t;

  typedef struct packed {
    logic [NOC_DW-1:0] data;
    logic              last;
    logic              err;
    logic [ID_X_W-1:0] sx;
    logic [ID_Y_W-1:0] sy;
  } entry_t;

  state_t            state_q, state_d;
  logic [ID_X_W-1:0] src_x_q, src_x_d;
  logic [ID_Y_W-1:0] src_y_q, src_y_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              err_valid_q;
  logic [2:0]        err_code_q, err_d;
  logic [15:0]       pkt_cnt_q;
  logic [7:0]        err_cnt_q;
  logic              pkt_done;

  entry_t            mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [CW-1:0]     cnt_q;
  logic              fifo_full, push, pop;
  entry_t            push_ent, rd_ent;

  // Flit decode.
  logic              is_hdr, is_tl, flit_acc;
  logic [NOC_DW-1:0] f_data;
  logic [ID_X_W-1:0] f_sx, f_dx;
  logic [ID_Y_W-1:0] f_sy, f_dy;
  logic [LEN_W-1:0]  f_len;
  logic              head_ok, tail_ok, dst_ok, src_ok, is_last;

  assign is_hdr   = bus.flit_in[NOC_DW+1];
  assign is_tl    = bus.flit_in[NOC_DW];
  assign f_data   = bus.flit_in[NOC_DW-1:0];
  assign f_sx     = f_data[SX_LSB +: ID_X_W];
  assign f_sy     = f_data[SY_LSB +: ID_Y_W];
  assign f_dx     = f_data[DX_LSB +: ID_X_W];
  assign f_dy     = f_data[DY_LSB +: ID_Y_W];
  assign f_len    = f_data[LEN_LSB +: LEN_W];
  assign head_ok  = (f_data[HM_LSB +: MARK_W] == HEAD_H) && (f_data[MARK_W-1:0] == HEAD_E);
  assign tail_ok  = (f_data[HM_LSB +: MARK_W] == TAIL_H) && (f_data[MARK_W-1:0] == TAIL_E);
  assign dst_ok   = (f_dx == ID_X_W'(X_ID)) && (f_dy == ID_Y_W'(Y_ID));
  assign src_ok   = (f_sx == src_x_q) && (f_sy == src_y_q);
  assign is_last  = (beat_cnt_q == len_q - LEN_W'(1));

  assign fifo_full      = (cnt_q == CW'(FIFO_DEPTH));
  assign bus.flit_ready = !fifo_full && !noc_rst;
  assign flit_acc       = bus.flit_valid && bus.flit_ready;
  assign pop            = (cnt_q != '0) && bus.pkt_ready;

  // Next-state, FIFO push and error classification for the accepted flit.
  always_comb begin
    state_d    = state_q;
    src_x_d    = src_x_q;
    src_y_d    = src_y_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    push       = 1'b0;
    push_ent   = '0;
    err_d      = E_NONE;
    pkt_done   = 1'b0;
    if (flit_acc) begin
      unique case (state_q)
        IDLE: begin
          if (!is_hdr) begin
            err_d = E_STRAY;
          end else if (is_tl || !head_ok) begin
            err_d   = E_BAD_HEAD;
            state_d = is_tl ? IDLE : DROP;
          end else if (!dst_ok) begin
            err_d   = E_MISROUTE;
            state_d = DROP;
          end else begin
            src_x_d    = f_sx;
            src_y_d    = f_sy;
            len_d      = f_len;
            beat_cnt_d = '0;
            state_d    = (f_len == '0) ? TAIL : PAYLOAD;
          end
        end
        PAYLOAD: begin
          push        = 1'b1;
          push_ent.sx = src_x_q;
          push_ent.sy = src_y_q;
          if (is_tl || is_hdr) begin
            // Early framing: close the stream with an abort terminator.
            err_d         = E_SHORT;
            push_ent.last = 1'b1;
            push_ent.err  = 1'b1;
            state_d       = is_tl ? IDLE : DROP;
          end else begin
            push_ent.data = f_data;
            push_ent.last = is_last;
            beat_cnt_d    = beat_cnt_q + LEN_W'(1);
            if (is_last) state_d = TAIL;
          end
        end
        TAIL: begin
          if (is_tl && tail_ok && src_ok) begin
            pkt_done = 1'b1;
            state_d  = IDLE;
          end else begin
            err_d   = E_BAD_TAIL;
            state_d = is_tl ? IDLE : DROP;
          end
        end
        DROP: begin
          if (is_tl) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Packet FSM, error reporting and counters.
  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      state_q     <= IDLE;
      src_x_q     <= '0;
      src_y_q     <= '0;
      len_q       <= '0;
      beat_cnt_q  <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= E_NONE;
      pkt_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      src_x_q     <= src_x_d;
      src_y_q     <= src_y_d;
      len_q       <= len_d;
      beat_cnt_q  <= beat_cnt_d;
      err_valid_q <= (err_d != E_NONE);
      if (err_d != E_NONE) begin
        err_code_q <= err_d;
        if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      end
      if (pkt_done) pkt_cnt_q <= pkt_cnt_q + 16'd1;
    end
  end

  // Payload FIFO pointers and occupancy; push never happens while full.
  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      if (push && !pop)      cnt_q <= cnt_q + CW'(1);
      else if (!push && pop) cnt_q <= cnt_q - CW'(1);
    end
  end

  // Payload storage; contents are don't-care until the pointers cover them.
  always_ff @(posedge noc_clk) begin
    if (push) mem_q[wr_q] <= push_ent;
  end

  assign rd_ent        = mem_q[rd_q];
  assign bus.pkt_valid = (cnt_q != '0);
  assign bus.pkt_data  = rd_ent.data;
  assign bus.pkt_last  = rd_ent.last;
  assign bus.pkt_err   = rd_ent.err;
  assign bus.pkt_src_x = rd_ent.sx;
  assign bus.pkt_src_y = rd_ent.sy;
  assign bus.err_valid = err_valid_q;
  assign bus.err_code  = err_code_q;
  assign bus.pkt_count = pkt_cnt_q;
  assign bus.err_count = err_cnt_q;

endmodule

// File: tb/tb_noc_packet_sink.sv
// Bench for noc_packet_sink at node (1,2): directed scenarios plus randomized packet mixes.
// Expected beats and error codes come from packet-level rules, not from the FSM.
// Consumer readiness is steady, random or held low depending on the scenario.
module tb_noc_packet_sink;
  logic noc_clk = 1'b0;
  logic noc_rst = 1'b1;
  always #5 noc_clk = ~noc_clk;

  noc_packet_sink_if #(.NOC_DW(64), .ID_X_W(2), .ID_Y_W(2)) bus ();

  noc_packet_sink #(
    .NOC_DW(64), .ID_X_W(2), .ID_Y_W(2), .LEN_W(8),
    .X_ID(1), .Y_ID(2), .FIFO_DEPTH(4), .MARK_W(4)
  ) dut (
    .noc_clk(noc_clk),
    .noc_rst(noc_rst),
    .bus    (bus)
  );

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic        err;
    logic [1:0]  sx;
    logic [1:0]  sy;
  } beat_t;

  beat_t exp_q[$];
  beat_t rx_q[$];
  int    exp_err[$];
  int    rx_err[$];
  beat_t mon_b;
  int    total = 0;
  int    bad = 0;
  int    exp_pkts = 0;
  int    exp_errs = 0;
  int    rdy_mode = 0;

  localparam logic [63:0] SPEC_H = 64'hA360_2000_0000_0005;
  localparam logic [63:0] SPEC_T = 64'hC360_2000_0000_0003;

  function automatic logic [63:0] mk_hdr(input logic [1:0] sx, input logic [1:0] sy,
                                         input logic [1:0] dx, input logic [1:0] dy,
                                         input logic [7:0] len);
    return {4'hA, sx, sy, dx, dy, len, 40'h0, 4'h5};
  endfunction

  function automatic logic [63:0] mk_tail(input logic [1:0] sx, input logic [1:0] sy);
    return {4'hC, sx, sy, 4'h6, 8'h00, 40'h0, 4'h3};
  endfunction

  function automatic logic [69:0] pk(input beat_t b);
    return {b.data, b.last, b.err, b.sx, b.sy};
  endfunction

  function automatic void exp_beat(input logic [63:0] d, input logic l, input logic e,
                                   input logic [1:0] sx, input logic [1:0] sy);
    beat_t b;
    b.data = d; b.last = l; b.err = e; b.sx = sx; b.sy = sy;
    exp_q.push_back(b);
  endfunction

  function automatic void exp_error(input int code);
    exp_err.push_back(code);
    if (exp_errs < 255) exp_errs++;
  endfunction

  function automatic void clear_all();
    exp_q.delete(); rx_q.delete(); exp_err.delete(); rx_err.delete();
  endfunction

  // Monitor: handshakes and error pulses seen mid-cycle complete at the next edge.
  initial begin
    forever begin
      @(negedge noc_clk);
      if (!noc_rst) begin
        if (bus.pkt_valid && bus.pkt_ready) begin
          mon_b.data = bus.pkt_data; mon_b.last = bus.pkt_last; mon_b.err = bus.pkt_err;
          mon_b.sx = bus.pkt_src_x; mon_b.sy = bus.pkt_src_y;
          rx_q.push_back(mon_b);
        end
        if (bus.err_valid) rx_err.push_back(int'(bus.err_code));
      end
    end
  end

  // Consumer readiness: 0 always ready, 1 random, 2 stalled.
  initial begin
    bus.pkt_ready = 1'b1;
    forever begin
      @(posedge noc_clk); #1;
      case (rdy_mode)
        0:       bus.pkt_ready = 1'b1;
        1:       bus.pkt_ready = 1'($urandom_range(0, 1));
        default: bus.pkt_ready = 1'b0;
      endcase
    end
  end

  task automatic send_flit(input logic h, input logic t, input logic [63:0] d);
    int w;
    w = 0;
    bus.flit_valid = 1'b1;
    bus.flit_in    = {h, t, d};
    @(negedge noc_clk);
    while (!bus.flit_ready && w < 300) begin
      w++;
      @(negedge noc_clk);
    end
    if (!bus.flit_ready) begin
      total++; bad++;
      $display("FAIL flit_accept_timeout flit_ready=%0b required=1", bus.flit_ready);
    end
    @(posedge noc_clk); #1;
    bus.flit_valid = 1'b0;
  endtask

  task automatic idle_gap(input int maxc);
    repeat ($urandom_range(0, maxc)) begin
      @(posedge noc_clk); #1;
    end
  endtask

  // A well-formed packet addressed to this node; the model expects every beat and a count.
  task automatic send_good(input logic [1:0] sx, input logic [1:0] sy, input int len, input int gap);
    logic [63:0] d;
    send_flit(1'b1, 1'b0, mk_hdr(sx, sy, 2'd1, 2'd2, 8'(len)));
    for (int i = 0; i < len; i++) begin
      idle_gap(gap);
      d = {$urandom, $urandom};
      send_flit(1'b0, 1'b0, d);
      exp_beat(d, (i == len - 1), 1'b0, sx, sy);
    end
    idle_gap(gap);
    send_flit(1'b0, 1'b1, mk_tail(sx, sy));
    exp_pkts++;
  endtask

  task automatic drain();
    int w;
    w = 0;
    rdy_mode = 0;
    while (rx_q.size() < exp_q.size() && w < 2000) begin
      @(posedge noc_clk);
      w++;
    end
    repeat (6) @(posedge noc_clk);
    #1;
  endtask

  task automatic test_reset();
    bus.flit_valid = 1'b0;
    bus.flit_in    = '0;
    repeat (3) @(posedge noc_clk);
    @(negedge noc_clk);
    total++; if (bus.flit_ready !== 1'b0) begin bad++; $display("FAIL rst_flit_ready got=%0b required=0", bus.flit_ready); end
    total++; if (bus.pkt_valid !== 1'b0) begin bad++; $display("FAIL rst_pkt_valid got=%0b required=0", bus.pkt_valid); end
    @(posedge noc_clk); #1;
    noc_rst = 1'b0;
    @(negedge noc_clk);
    total++; if (bus.flit_ready !== 1'b1) begin bad++; $display("FAIL post_rst_flit_ready got=%0b required=1", bus.flit_ready); end
    total++; if (bus.pkt_count !== 16'd0) begin bad++; $display("FAIL rst_pkt_count got=%0d required=0", bus.pkt_count); end
    total++; if (bus.err_count !== 8'd0) begin bad++; $display("FAIL rst_err_count got=%0d required=0", bus.err_count); end
    total++; if (bus.err_code !== 3'd0 || bus.err_valid !== 1'b0) begin
      bad++; $display("FAIL rst_err code=%0d valid=%0b required=0/0", bus.err_code, bus.err_valid);
    end
    @(posedge noc_clk); #1;
  endtask

  task automatic test_good_packet();
    logic [63:0] d0, d1;
    clear_all();
    d0 = 64'h0123_4567_89AB_CDEF;
    d1 = 64'hFEDC_BA98_7654_3210;
    send_flit(1'b1, 1'b0, SPEC_H);
    send_flit(1'b0, 1'b0, d0);
    send_flit(1'b0, 1'b0, d1);
    send_flit(1'b0, 1'b1, SPEC_T);
    exp_beat(d0, 1'b0, 1'b0, 2'd0, 2'd3);
    exp_beat(d1, 1'b1, 1'b0, 2'd0, 2'd3);
    exp_pkts++;
    drain();
    total++; if (rx_q.size() !== exp_q.size()) begin bad++; $display("FAIL good_nbeats got=%0d required=%0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      total++; if (pk(rx_q[i]) !== pk(exp_q[i])) begin bad++; $display("FAIL good_beat%0d got=%h required=%h", i, pk(rx_q[i]), pk(exp_q[i])); end
    end
    total++; if (rx_err.size() !== 0) begin bad++; $display("FAIL good_err_pulses got=%0d required=0", rx_err.size()); end
    total++; if (int'(bus.pkt_count) !== exp_pkts) begin bad++; $display("FAIL good_pkt_count got=%0d required=%0d", bus.pkt_count, exp_pkts); end
  endtask

  task automatic test_backpressure();
    logic [63:0] d [6];
    int seen;
    clear_all();
    rdy_mode = 2;
    repeat (2) begin @(posedge noc_clk); #1; end
    foreach (d[i]) d[i] = {$urandom, $urandom};
    send_flit(1'b1, 1'b0, mk_hdr(2'd0, 2'd3, 2'd1, 2'd2, 8'd6));
    for (int i = 0; i < 4; i++) send_flit(1'b0, 1'b0, d[i]);
    bus.flit_valid = 1'b1;
    bus.flit_in    = {2'b00, d[4]};
    seen = 0;
    repeat (4) begin
      @(negedge noc_clk);
      if (bus.flit_ready) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL bp_stall ready_cycles=%0d required=0", seen); end
    total++; if (rx_q.size() !== 0) begin bad++; $display("FAIL bp_no_pop got=%0d required=0", rx_q.size()); end
    rdy_mode = 0;
    send_flit(1'b0, 1'b0, d[4]);
    send_flit(1'b0, 1'b0, d[5]);
    send_flit(1'b0, 1'b1, mk_tail(2'd0, 2'd3));
    for (int i = 0; i < 6; i++) exp_beat(d[i], (i == 5), 1'b0, 2'd0, 2'd3);
    exp_pkts++;
    drain();
    total++; if (rx_q.size() !== exp_q.size()) begin bad++; $display("FAIL bp_nbeats got=%0d required=%0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      total++; if (pk(rx_q[i]) !== pk(exp_q[i])) begin bad++; $display("FAIL bp_beat%0d got=%h required=%h", i, pk(rx_q[i]), pk(exp_q[i])); end
    end
    total++; if (int'(bus.pkt_count) !== exp_pkts) begin bad++; $display("FAIL bp_pkt_count got=%0d required=%0d", bus.pkt_count, exp_pkts); end
  endtask

  task automatic test_misroute();
    clear_all();
    send_flit(1'b1, 1'b0, 64'hA370_2000_0000_0005);
    send_flit(1'b0, 1'b0, {$urandom, $urandom});
    send_flit(1'b0, 1'b0, {$urandom, $urandom});
    send_flit(1'b0, 1'b1, mk_tail(2'd0, 2'd3));
    exp_error(3);
    drain();
    total++; if (rx_q.size() !== 0) begin bad++; $display("FAIL mis_nbeats got=%0d required=0", rx_q.size()); end
    total++; if (bus.err_code !== 3'd3) begin bad++; $display("FAIL mis_err_code got=%0d required=3", bus.err_code); end
    total++; if (int'(bus.err_count) !== exp_errs) begin bad++; $display("FAIL mis_err_count got=%0d required=%0d", bus.err_count, exp_errs); end
    total++; if (rx_err.size() !== 1) begin bad++; $display("FAIL mis_err_pulses got=%0d required=1", rx_err.size()); end
    send_good(2'd2, 2'd1, 1, 0);
    drain();
    total++; if (rx_q.size() !== 1 || pk(rx_q[0]) !== pk(exp_q[0])) begin
      bad++; $display("FAIL mis_followup_beats got=%0d required=1", rx_q.size());
    end
  endtask

  task automatic test_short();
    logic [63:0] d0;
    clear_all();
    d0 = {$urandom, $urandom};
    send_flit(1'b1, 1'b0, mk_hdr(2'd0, 2'd3, 2'd1, 2'd2, 8'd2));
    send_flit(1'b0, 1'b0, d0);
    send_flit(1'b0, 1'b1, SPEC_T);
    exp_beat(d0, 1'b0, 1'b0, 2'd0, 2'd3);
    exp_beat(64'd0, 1'b1, 1'b1, 2'd0, 2'd3);
    exp_error(4);
    drain();
    total++; if (rx_q.size() !== exp_q.size()) begin bad++; $display("FAIL short_nbeats got=%0d required=%0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      total++; if (pk(rx_q[i]) !== pk(exp_q[i])) begin bad++; $display("FAIL short_beat%0d got=%h required=%h", i, pk(rx_q[i]), pk(exp_q[i])); end
    end
    total++; if (bus.err_code !== 3'd4) begin bad++; $display("FAIL short_err_code got=%0d required=4", bus.err_code); end
  endtask

  task automatic test_stray();
    clear_all();
    send_flit(1'b0, 1'b0, {$urandom, $urandom});
    exp_error(1);
    send_good(2'd3, 2'd3, 3, 0);
    drain();
    total++; if (rx_err.size() !== 1 || rx_err[0] !== 1) begin bad++; $display("FAIL stray_err pulses=%0d required=1 with code 1", rx_err.size()); end
    total++; if (rx_q.size() !== exp_q.size()) begin bad++; $display("FAIL stray_nbeats got=%0d required=%0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      total++; if (pk(rx_q[i]) !== pk(exp_q[i])) begin bad++; $display("FAIL stray_beat%0d got=%h required=%h", i, pk(rx_q[i]), pk(exp_q[i])); end
    end
  endtask

  task automatic test_len_zero();
    clear_all();
    send_good(2'd1, 2'd0, 0, 0);
    drain();
    total++; if (rx_q.size() !== 0) begin bad++; $display("FAIL len0_nbeats got=%0d required=0", rx_q.size()); end
    total++; if (int'(bus.pkt_count) !== exp_pkts) begin bad++; $display("FAIL len0_pkt_count got=%0d required=%0d", bus.pkt_count, exp_pkts); end
  endtask

  task automatic test_random();
    logic [1:0] sx, sy, dx, dy;
    int kind, len, k;
    clear_all();
    rdy_mode = 1;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 4);
      sx = 2'($urandom); sy = 2'($urandom);
      rdy_mode = 1;
      case (kind)
        0: send_good(sx, sy, $urandom_range(0, 5), 2);
        1: begin
          dx = 2'($urandom); dy = 2'($urandom);
          if (dx == 2'd1 && dy == 2'd2) dy = 2'd0;
          send_flit(1'b1, 1'b0, mk_hdr(sx, sy, dx, dy, 8'($urandom_range(1, 4))));
          k = $urandom_range(0, 3);
          for (int i = 0; i < k; i++) send_flit(1'b0, 1'b0, {$urandom, $urandom});
          send_flit(1'b0, 1'b1, mk_tail(sx, sy));
          exp_error(3);
        end
        2: begin
          len = $urandom_range(2, 5);
          k = $urandom_range(0, len - 1);
          send_flit(1'b1, 1'b0, mk_hdr(sx, sy, 2'd1, 2'd2, 8'(len)));
          for (int i = 0; i < k; i++) begin
            logic [63:0] d;
            d = {$urandom, $urandom};
            send_flit(1'b0, 1'b0, d);
            exp_beat(d, 1'b0, 1'b0, sx, sy);
          end
          send_flit(1'b0, 1'b1, mk_tail(sx, sy));
          exp_beat(64'd0, 1'b1, 1'b1, sx, sy);
          exp_error(4);
        end
        3: begin
          send_flit(1'b0, 1'($urandom), {$urandom, $urandom});
          exp_error(1);
        end
        default: begin
          len = $urandom_range(0, 3);
          send_flit(1'b1, 1'b0, mk_hdr(sx, sy, 2'd1, 2'd2, 8'(len)));
          for (int i = 0; i < len; i++) begin
            logic [63:0] d;
            d = {$urandom, $urandom};
            send_flit(1'b0, 1'b0, d);
            exp_beat(d, (i == len - 1), 1'b0, sx, sy);
          end
          send_flit(1'b0, 1'b1, mk_tail(sx ^ 2'b01, sy));
          exp_error(5);
        end
      endcase
    end
    drain();
    total++; if (rx_q.size() !== exp_q.size()) begin bad++; $display("FAIL rnd_nbeats got=%0d required=%0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      total++; if (pk(rx_q[i]) !== pk(exp_q[i])) begin bad++; $display("FAIL rnd_beat%0d got=%h required=%h", i, pk(rx_q[i]), pk(exp_q[i])); end
    end
    total++; if (rx_err.size() !== exp_err.size()) begin bad++; $display("FAIL rnd_nerr got=%0d required=%0d", rx_err.size(), exp_err.size()); end
    for (int i = 0; i < exp_err.size() && i < rx_err.size(); i++) begin
      total++; if (rx_err[i] !== exp_err[i]) begin bad++; $display("FAIL rnd_err%0d got=%0d required=%0d", i, rx_err[i], exp_err[i]); end
    end
    total++; if (int'(bus.pkt_count) !== exp_pkts) begin bad++; $display("FAIL rnd_pkt_count got=%0d required=%0d", bus.pkt_count, exp_pkts); end
    total++; if (int'(bus.err_count) !== exp_errs) begin bad++; $display("FAIL rnd_err_count got=%0d required=%0d", bus.err_count, exp_errs); end
  endtask

  task automatic test_reset_mid();
    clear_all();
    rdy_mode = 2;
    repeat (2) begin @(posedge noc_clk); #1; end
    send_flit(1'b1, 1'b0, mk_hdr(2'd0, 2'd3, 2'd1, 2'd2, 8'd3));
    send_flit(1'b0, 1'b0, {$urandom, $urandom});
    @(negedge noc_clk);
    total++; if (bus.pkt_valid !== 1'b1) begin bad++; $display("FAIL rmid_pre_valid got=%0b required=1", bus.pkt_valid); end
    @(posedge noc_clk); #1;
    noc_rst = 1'b1;
    @(negedge noc_clk);
    total++; if (bus.flit_ready !== 1'b0) begin bad++; $display("FAIL rmid_flit_ready got=%0b required=0", bus.flit_ready); end
    @(posedge noc_clk);
    @(negedge noc_clk);
    total++; if (bus.pkt_valid !== 1'b0) begin bad++; $display("FAIL rmid_pkt_valid got=%0b required=0", bus.pkt_valid); end
    total++; if (bus.pkt_count !== 16'd0 || bus.err_count !== 8'd0) begin
      bad++; $display("FAIL rmid_counters pkt=%0d err=%0d required=0/0", bus.pkt_count, bus.err_count);
    end
    @(posedge noc_clk); #1;
    noc_rst  = 1'b0;
    rdy_mode = 0;
    exp_pkts = 0;
    exp_errs = 0;
    clear_all();
    send_good(2'd3, 2'd0, 2, 1);
    drain();
    total++; if (rx_q.size() !== exp_q.size()) begin bad++; $display("FAIL rmid_nbeats got=%0d required=%0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      total++; if (pk(rx_q[i]) !== pk(exp_q[i])) begin bad++; $display("FAIL rmid_beat%0d got=%h required=%h", i, pk(rx_q[i]), pk(exp_q[i])); end
    end
    total++; if (rx_err.size() !== 0) begin bad++; $display("FAIL rmid_err_pulses got=%0d required=0", rx_err.size()); end
    total++; if (int'(bus.pkt_count) !== exp_pkts) begin bad++; $display("FAIL rmid_pkt_count got=%0d required=%0d", bus.pkt_count, exp_pkts); end
  endtask

  task automatic test_err_saturate();
    clear_all();
    for (int i = 0; i < 260; i++) begin
      send_flit(1'b0, 1'b0, {$urandom, $urandom});
      exp_error(1);
    end
    drain();
    total++; if (rx_err.size() !== 260) begin bad++; $display("FAIL sat_err_pulses got=%0d required=260", rx_err.size()); end
    total++; if (int'(bus.err_count) !== exp_errs) begin bad++; $display("FAIL sat_err_count got=%0d required=%0d", bus.err_count, exp_errs); end
    total++; if (bus.err_code !== 3'd1) begin bad++; $display("FAIL sat_err_code got=%0d required=1", bus.err_code); end
    total++; if (int'(bus.pkt_count) !== exp_pkts) begin bad++; $display("FAIL sat_pkt_count got=%0d required=%0d", bus.pkt_count, exp_pkts); end
  endtask

  initial begin
    bus.flit_valid = 1'b0;
    bus.flit_in    = '0;
    test_reset();
    test_good_packet();
    test_backpressure();
    test_misroute();
    test_short();
    test_stray();
    test_len_zero();
    test_random();
    test_reset_mid();
    test_err_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
